// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_pkg
// Description : Shared constants and types for the hazard/forwarding unit.
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_pkg;

    localparam int DEFAULT_REG_AW = 5;

    // EX operand source selects
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic [0:0] {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

endpackage
`default_nettype wire

// File: rtl/hazard_forward_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : hazard_forward_unit_if
// Description : Pipeline-side bundle feeding the hazard/forwarding unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface hazard_forward_unit_if
    import hazard_pkg::*;
#(
    parameter int REG_AW = DEFAULT_REG_AW,
    parameter int CNT_W  = 32
);
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_uses_rs;
    logic              id_uses_rt;
    logic              id_is_branch;
    logic              id_md_op;
    logic              id_hilo_read;
    logic              flush_id;
    logic [REG_AW-1:0] ex_rs;
    logic [REG_AW-1:0] ex_rt;
    logic [REG_AW-1:0] ex_dst;
    logic              ex_reg_write;
    logic              ex_mem_read;
    logic              md_start;
    logic [REG_AW-1:0] mem_dst;
    logic              mem_reg_write;
    logic              mem_mem_read;
    logic [REG_AW-1:0] wb_dst;
    logic              wb_reg_write;
    logic              cnt_clr;
    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;
    logic              fwd_c;
    logic              fwd_d;
    logic              stall;
    logic              bubble;
    logic              md_busy;
    logic [CNT_W-1:0]  stall_count;

    modport master (
        output id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_branch, id_md_op,
               id_hilo_read, flush_id, ex_rs, ex_rt, ex_dst, ex_reg_write,
               ex_mem_read, md_start, mem_dst, mem_reg_write, mem_mem_read,
               wb_dst, wb_reg_write, cnt_clr,
        input  fwd_a, fwd_b, fwd_c, fwd_d, stall, bubble, md_busy, stall_count
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_branch, id_md_op,
               id_hilo_read, flush_id, ex_rs, ex_rt, ex_dst, ex_reg_write,
               ex_mem_read, md_start, mem_dst, mem_reg_write, mem_mem_read,
               wb_dst, wb_reg_write, cnt_clr,
        output fwd_a, fwd_b, fwd_c, fwd_d, stall, bubble, md_busy, stall_count
    );

endinterface
`default_nettype wire

// File: rtl/hazard_forward_unit_md_busy_tracker.sv
`default_nettype none
// ============================================================================
// Module      : md_busy_tracker
// Description : Tracks the multi-cycle mul/div unit; busy for MD_LAT cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module md_busy_tracker
    import hazard_pkg::*;
#(
    parameter int MD_LAT = 4
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_md_start,
    output logic      o_md_busy
);

    localparam int c_CNT_W = $clog2(MD_LAT + 1);

    md_state_t          r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_md_busy;

    // A start while already busy is ignored: the count is never reloaded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= MD_IDLE;
            r_cnt     <= '0;
            r_md_busy <= 1'b0;
        end else begin
            case (r_state)
                MD_IDLE: begin
                    if (i_md_start) begin
                        r_state   <= MD_BUSY;
                        r_cnt     <= c_CNT_W'(MD_LAT);
                        r_md_busy <= 1'b1;
                    end
                end
                MD_BUSY: begin
                    if (r_cnt == c_CNT_W'(1)) begin
                        r_state   <= MD_IDLE;
                        r_cnt     <= '0;
                        r_md_busy <= 1'b0;
                    end else begin
                        r_cnt     <= r_cnt - c_CNT_W'(1);
                    end
                end
                default: begin
                    r_state   <= MD_IDLE;
                    r_cnt     <= '0;
                    r_md_busy <= 1'b0;
                end
            endcase
        end
    end

    assign o_md_busy = r_md_busy;

endmodule
`default_nettype wire

// File: rtl/hazard_forward_unit.sv
`default_nettype none
// ============================================================================
// Module      : hazard_forward_unit
// Description : Forwarding selects, stall/bubble control and stall counter.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_forward_unit
    import hazard_pkg::*;
#(
    parameter int REG_AW = DEFAULT_REG_AW,
    parameter int MD_LAT = 4,
    parameter int CNT_W  = 32
) (
    input  wire logic             clk,
    input  wire logic             rst,
    hazard_forward_unit_if.slave  hz
);

    localparam logic [REG_AW-1:0] c_R0  = '0;
    localparam logic [CNT_W-1:0]  c_MAX = '1;

    logic [1:0]       w_fwd_a;
    logic [1:0]       w_fwd_b;
    logic             w_fwd_c;
    logic             w_fwd_d;
    logic             w_ex_hit;
    logic             w_mem_hit;
    logic             w_stall_l;
    logic             w_stall_b1;
    logic             w_stall_b2;
    logic             w_stall_m;
    logic             w_stall;
    logic             w_md_busy;
    logic [CNT_W-1:0] r_stall_count;

    // EX/MEM has priority because it holds the younger result.
    always_comb begin
        w_fwd_a = FWD_RF;
        if (hz.mem_reg_write && hz.mem_dst != c_R0 && hz.mem_dst == hz.ex_rs)
            w_fwd_a = FWD_MEM;
        else if (hz.wb_reg_write && hz.wb_dst != c_R0 && hz.wb_dst == hz.ex_rs)
            w_fwd_a = FWD_WB;

        w_fwd_b = FWD_RF;
        if (hz.mem_reg_write && hz.mem_dst != c_R0 && hz.mem_dst == hz.ex_rt)
            w_fwd_b = FWD_MEM;
        else if (hz.wb_reg_write && hz.wb_dst != c_R0 && hz.wb_dst == hz.ex_rt)
            w_fwd_b = FWD_WB;
    end

    // A load result in MEM is not yet available for the ID comparator.
    assign w_fwd_c = hz.mem_reg_write && !hz.mem_mem_read &&
                     hz.mem_dst != c_R0 && hz.mem_dst == hz.id_rs;
    assign w_fwd_d = hz.mem_reg_write && !hz.mem_mem_read &&
                     hz.mem_dst != c_R0 && hz.mem_dst == hz.id_rt;

    assign w_ex_hit  = hz.ex_dst != c_R0 &&
                       ((hz.id_uses_rs && hz.ex_dst == hz.id_rs) ||
                        (hz.id_uses_rt && hz.ex_dst == hz.id_rt));
    assign w_mem_hit = hz.mem_dst != c_R0 &&
                       ((hz.id_uses_rs && hz.mem_dst == hz.id_rs) ||
                        (hz.id_uses_rt && hz.mem_dst == hz.id_rt));

    assign w_stall_l  = hz.ex_mem_read && hz.ex_reg_write && w_ex_hit;
    assign w_stall_b1 = hz.id_is_branch && hz.ex_reg_write && w_ex_hit;
    assign w_stall_b2 = hz.id_is_branch && hz.mem_mem_read &&
                        hz.mem_reg_write && w_mem_hit;
    assign w_stall_m  = (hz.id_md_op || hz.id_hilo_read) &&
                        (w_md_busy || hz.md_start);
    assign w_stall    = (w_stall_l || w_stall_b1 || w_stall_b2 || w_stall_m) &&
                        !hz.flush_id && !rst;

    md_busy_tracker #(
        .MD_LAT (MD_LAT)
    ) u_md_busy_tracker (
        .clk        (clk),
        .rst        (rst),
        .i_md_start (hz.md_start),
        .o_md_busy  (w_md_busy)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_stall_count <= '0;
        else if (hz.cnt_clr)
            r_stall_count <= '0;
        else if (w_stall && r_stall_count != c_MAX)
            r_stall_count <= r_stall_count + CNT_W'(1);
    end

    assign hz.fwd_a       = w_fwd_a;
    assign hz.fwd_b       = w_fwd_b;
    assign hz.fwd_c       = w_fwd_c;
    assign hz.fwd_d       = w_fwd_d;
    assign hz.stall       = w_stall;
    assign hz.bubble      = w_stall;
    assign hz.md_busy     = w_md_busy;
    assign hz.stall_count = r_stall_count;

endmodule
`default_nettype wire

// File: tb/tb_hazard_forward_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_forward_unit
// Description : Directed self-checking bench for hazard_forward_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_forward_unit;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    hazard_forward_unit_if #(.REG_AW(5), .CNT_W(4)) hz ();

    hazard_forward_unit #(
        .REG_AW (5),
        .MD_LAT (4),
        .CNT_W  (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A second mul/div may never issue while the unit is occupied.
    always @(posedge clk) begin
        if (!rst) assert (!(hz.md_start && hz.md_busy));
    end

    task automatic idle_inputs();
        hz.id_rs = '0; hz.id_rt = '0; hz.id_uses_rs = 0; hz.id_uses_rt = 0;
        hz.id_is_branch = 0; hz.id_md_op = 0; hz.id_hilo_read = 0; hz.flush_id = 0;
        hz.ex_rs = '0; hz.ex_rt = '0; hz.ex_dst = '0; hz.ex_reg_write = 0;
        hz.ex_mem_read = 0; hz.md_start = 0; hz.mem_dst = '0; hz.mem_reg_write = 0;
        hz.mem_mem_read = 0; hz.wb_dst = '0; hz.wb_reg_write = 0; hz.cnt_clr = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_count();
        hz.cnt_clr = 1;
        tick();
        hz.cnt_clr = 0;
    endtask

    task automatic set_load_use();
        hz.ex_mem_read = 1; hz.ex_reg_write = 1; hz.ex_dst = 5'd8;
        hz.id_rs = 5'd8; hz.id_uses_rs = 1;
    endtask

    task automatic test_reset();
        rst = 1;
        idle_inputs();
        set_load_use();
        hz.mem_reg_write = 1; hz.mem_dst = 5'd3; hz.ex_rs = 5'd3;
        tick();
        total++; if (hz.stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", hz.stall); end
        total++; if (hz.bubble !== 1'b0) begin bad++; $display("FAIL reset_bubble got=%b want=0", hz.bubble); end
        total++; if (hz.md_busy !== 1'b0) begin bad++; $display("FAIL reset_md_busy got=%b want=0", hz.md_busy); end
        total++; if (hz.stall_count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", hz.stall_count); end
        total++; if (hz.fwd_a !== 2'b10) begin bad++; $display("FAIL reset_fwd_comb got=%b want=10", hz.fwd_a); end
        rst = 0;
        idle_inputs();
        tick();
    endtask

    task automatic test_ex_forward();
        idle_inputs();
        hz.ex_rs = 5'd5; hz.mem_dst = 5'd5; hz.mem_reg_write = 1; hz.wb_dst = 5'd5; hz.wb_reg_write = 1;
        #1;
        total++; if (hz.fwd_a !== 2'b10) begin bad++; $display("FAIL fwd_a_mem got=%b want=10", hz.fwd_a); end
        total++; if (hz.fwd_b !== 2'b00) begin bad++; $display("FAIL fwd_b_none got=%b want=00", hz.fwd_b); end
        hz.mem_reg_write = 0;
        #1;
        total++; if (hz.fwd_a !== 2'b01) begin bad++; $display("FAIL fwd_a_wb got=%b want=01", hz.fwd_a); end
        hz.ex_rs = 5'd0; hz.mem_dst = 5'd0; hz.wb_dst = 5'd0; hz.mem_reg_write = 1;
        #1;
        total++; if (hz.fwd_a !== 2'b00) begin bad++; $display("FAIL fwd_a_r0 got=%b want=00", hz.fwd_a); end
        idle_inputs();
        hz.ex_rt = 5'd7; hz.mem_dst = 5'd7; hz.mem_reg_write = 1; hz.wb_dst = 5'd7; hz.wb_reg_write = 1;
        #1;
        total++; if (hz.fwd_b !== 2'b10) begin bad++; $display("FAIL fwd_b_mem got=%b want=10", hz.fwd_b); end
        hz.mem_reg_write = 0;
        #1;
        total++; if (hz.fwd_b !== 2'b01) begin bad++; $display("FAIL fwd_b_wb got=%b want=01", hz.fwd_b); end
        hz.ex_rt = 5'd0; hz.mem_dst = 5'd0; hz.wb_dst = 5'd0; hz.mem_reg_write = 1;
        #1;
        total++; if (hz.fwd_b !== 2'b00) begin bad++; $display("FAIL fwd_b_r0 got=%b want=00", hz.fwd_b); end
        idle_inputs();
    endtask

    task automatic test_load_use();
        idle_inputs();
        set_load_use();
        #1;
        total++; if (hz.stall !== 1'b1) begin bad++; $display("FAIL lu_stall got=%b want=1", hz.stall); end
        total++; if (hz.bubble !== 1'b1) begin bad++; $display("FAIL lu_bubble got=%b want=1", hz.bubble); end
        hz.id_uses_rs = 0;
        #1;
        total++; if (hz.stall !== 1'b0) begin bad++; $display("FAIL lu_unused got=%b want=0", hz.stall); end
        hz.id_rt = 5'd8; hz.id_uses_rt = 1;
        #1;
        total++; if (hz.stall !== 1'b1) begin bad++; $display("FAIL lu_rt got=%b want=1", hz.stall); end
        hz.ex_dst = 5'd0; hz.id_rt = 5'd0; hz.id_rs = 5'd0; hz.id_uses_rs = 1;
        #1;
        total++; if (hz.stall !== 1'b0) begin bad++; $display("FAIL lu_r0 got=%b want=0", hz.stall); end
        idle_inputs();
    endtask

    task automatic test_branch_after_load();
        idle_inputs();
        clear_count();
        hz.id_is_branch = 1; hz.id_rs = 5'd9; hz.id_uses_rs = 1;
        hz.ex_dst = 5'd9; hz.ex_reg_write = 1; hz.ex_mem_read = 1;
        #1;
        total++; if (hz.stall !== 1'b1) begin bad++; $display("FAIL bl_c0_stall got=%b want=1", hz.stall); end
        tick();
        hz.ex_dst = 5'd0; hz.ex_reg_write = 0; hz.ex_mem_read = 0;
        hz.mem_dst = 5'd9; hz.mem_reg_write = 1; hz.mem_mem_read = 1;
        #1;
        total++; if (hz.stall !== 1'b1) begin bad++; $display("FAIL bl_c1_stall got=%b want=1", hz.stall); end
        total++; if (hz.fwd_c !== 1'b0) begin bad++; $display("FAIL bl_c1_fwd_c got=%b want=0", hz.fwd_c); end
        tick();
        hz.mem_dst = 5'd0; hz.mem_reg_write = 0; hz.mem_mem_read = 0;
        hz.wb_dst = 5'd9; hz.wb_reg_write = 1;
        #1;
        total++; if (hz.stall !== 1'b0) begin bad++; $display("FAIL bl_c2_stall got=%b want=0", hz.stall); end
        total++; if (hz.fwd_c !== 1'b0) begin bad++; $display("FAIL bl_c2_fwd_c got=%b want=0", hz.fwd_c); end
        total++; if (hz.stall_count !== 4'd2) begin bad++; $display("FAIL bl_count got=%0d want=2", hz.stall_count); end
        idle_inputs();
    endtask

    task automatic test_branch_after_alu();
        idle_inputs();
        clear_count();
        hz.id_is_branch = 1; hz.id_rs = 5'd9; hz.id_rt = 5'd9; hz.id_uses_rs = 1; hz.id_uses_rt = 1;
        hz.ex_dst = 5'd9; hz.ex_reg_write = 1;
        #1;
        total++; if (hz.stall !== 1'b1) begin bad++; $display("FAIL ba_c0_stall got=%b want=1", hz.stall); end
        tick();
        hz.ex_dst = 5'd0; hz.ex_reg_write = 0;
        hz.mem_dst = 5'd9; hz.mem_reg_write = 1;
        #1;
        total++; if (hz.stall !== 1'b0) begin bad++; $display("FAIL ba_c1_stall got=%b want=0", hz.stall); end
        total++; if (hz.fwd_c !== 1'b1) begin bad++; $display("FAIL ba_fwd_c got=%b want=1", hz.fwd_c); end
        total++; if (hz.fwd_d !== 1'b1) begin bad++; $display("FAIL ba_fwd_d got=%b want=1", hz.fwd_d); end
        total++; if (hz.stall_count !== 4'd1) begin bad++; $display("FAIL ba_count got=%0d want=1", hz.stall_count); end
        idle_inputs();
    endtask

    task automatic test_md_interlock();
        idle_inputs();
        clear_count();
        hz.id_hilo_read = 1; hz.md_start = 1;
        #1;
        total++; if (hz.stall !== 1'b1) begin bad++; $display("FAIL md_c0_stall got=%b want=1", hz.stall); end
        total++; if (hz.md_busy !== 1'b0) begin bad++; $display("FAIL md_c0_busy got=%b want=0", hz.md_busy); end
        tick();
        hz.md_start = 0;
        for (int c = 1; c <= 4; c++) begin
            #1;
            total++; if (hz.stall !== 1'b1) begin bad++; $display("FAIL md_c%0d_stall got=%b want=1", c, hz.stall); end
            total++; if (hz.md_busy !== 1'b1) begin bad++; $display("FAIL md_c%0d_busy got=%b want=1", c, hz.md_busy); end
            tick();
        end
        #1;
        total++; if (hz.stall !== 1'b0) begin bad++; $display("FAIL md_c5_stall got=%b want=0", hz.stall); end
        total++; if (hz.md_busy !== 1'b0) begin bad++; $display("FAIL md_c5_busy got=%b want=0", hz.md_busy); end
        total++; if (hz.stall_count !== 4'd5) begin bad++; $display("FAIL md_count got=%0d want=5", hz.stall_count); end
        idle_inputs();
    endtask

    task automatic test_async_reset();
        idle_inputs();
        clear_count();
        set_load_use();
        repeat (7) tick();
        idle_inputs();
        hz.md_start = 1;
        tick();
        hz.md_start = 0;
        total++; if (hz.stall_count !== 4'd7) begin bad++; $display("FAIL ar_pre_count got=%0d want=7", hz.stall_count); end
        total++; if (hz.md_busy !== 1'b1) begin bad++; $display("FAIL ar_pre_busy got=%b want=1", hz.md_busy); end
        hz.id_hilo_read = 1;
        #2;
        rst = 1;
        #1;
        total++; if (hz.md_busy !== 1'b0) begin bad++; $display("FAIL ar_busy got=%b want=0", hz.md_busy); end
        total++; if (hz.stall_count !== 4'd0) begin bad++; $display("FAIL ar_count got=%0d want=0", hz.stall_count); end
        total++; if (hz.stall !== 1'b0) begin bad++; $display("FAIL ar_stall got=%b want=0", hz.stall); end
        #1;
        rst = 0;
        idle_inputs();
        tick();
        hz.md_start = 1;
        tick();
        hz.md_start = 0;
        total++; if (hz.md_busy !== 1'b1) begin bad++; $display("FAIL ar_resume_busy got=%b want=1", hz.md_busy); end
        repeat (4) tick();
        total++; if (hz.md_busy !== 1'b0) begin bad++; $display("FAIL ar_resume_idle got=%b want=0", hz.md_busy); end
        idle_inputs();
    endtask

    task automatic test_flush_and_saturate();
        idle_inputs();
        set_load_use();
        hz.flush_id = 1;
        #1;
        total++; if (hz.stall !== 1'b0) begin bad++; $display("FAIL flush_stall got=%b want=0", hz.stall); end
        total++; if (hz.bubble !== 1'b0) begin bad++; $display("FAIL flush_bubble got=%b want=0", hz.bubble); end
        idle_inputs();
        clear_count();
        set_load_use();
        repeat (20) tick();
        total++; if (hz.stall_count !== 4'd15) begin bad++; $display("FAIL sat_count got=%0d want=15", hz.stall_count); end
        total++; if (hz.stall !== 1'b1) begin bad++; $display("FAIL sat_stall got=%b want=1", hz.stall); end
        hz.cnt_clr = 1;
        tick();
        hz.cnt_clr = 0;
        total++; if (hz.stall_count !== 4'd0) begin bad++; $display("FAIL clr_count got=%0d want=0", hz.stall_count); end
        tick();
        total++; if (hz.stall_count !== 4'd1) begin bad++; $display("FAIL clr_resume got=%0d want=1", hz.stall_count); end
        idle_inputs();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_ex_forward();
        test_load_use();
        test_branch_after_load();
        test_branch_after_alu();
        test_md_interlock();
        test_async_reset();
        test_flush_and_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
